// File: rtl/sne_route_pkg.sv
// Shared types and defaults for the event-stream routing selector.
// The typedefs describe the default configuration; modules that are
// parameterised away from it size their own vectors from their parameters.
package sne_route_pkg;

    localparam int unsigned DEF_N_OUP   = 2;
    localparam int unsigned DEF_N_KEYS  = 16;
    localparam int unsigned DEF_KEY_LSB = 0;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_EVT_W   = 16;

    // Routing key slice and destination mask for the default configuration.
    typedef logic [$clog2(DEF_N_KEYS)-1:0] route_key_t;
    typedef logic [DEF_N_OUP-1:0]          route_mask_t;

    // Table reset value: broadcast to every fork output.
    localparam route_mask_t DEF_RST_MASK = '1;

endpackage

// File: rtl/SNE_EVENT_STREAM.sv
// Event stream handshake bundle.
// valid/ready: the producer raises valid with stable evt and holds both until
// a cycle in which ready is also high; that cycle is the transfer. The
// consumer may drive ready independently of valid.
interface SNE_EVENT_STREAM #(
    parameter int unsigned EVT_W = 16
);
    logic             valid;
    logic             ready;
    logic [EVT_W-1:0] evt;

    modport src (output valid, output evt, input ready);
    modport dst (input valid, input evt, output ready);
endinterface

// File: rtl/evt_route_table.sv
// Routing table: register array with one synchronous write port and one
// combinational read port. A write becomes visible to reads from the next
// cycle, so a lookup in the write cycle sees the old entry.
module evt_route_table #(
    parameter int unsigned       N_OUP    = 2,
    parameter int unsigned       N_KEYS   = 16,
    parameter logic [N_OUP-1:0]  RST_MASK = '1,
    localparam int unsigned      KEY_W    = $clog2(N_KEYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [KEY_W-1:0] waddr_i,
    input  logic [N_OUP-1:0] wdata_i,
    input  logic [KEY_W-1:0] raddr_i,
    output logic [N_OUP-1:0] rdata_o
);

    logic [N_OUP-1:0] mem_q [N_KEYS];

    // Table storage: every entry returns to RST_MASK on reset, else one write per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                mem_q[i] <= RST_MASK;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/evt_stream_route_sel.sv
// Event-stream routing selector: looks up a destination mask per event,
// registers event and mask in one output stage and presents them on the
// event and select handshakes of the downstream fork. Events whose mask is
// all-zero are consumed without being forwarded and counted.
module evt_stream_route_sel
    import sne_route_pkg::*;
#(
    parameter int unsigned      N_OUP    = DEF_N_OUP,
    parameter int unsigned      N_KEYS   = DEF_N_KEYS,
    parameter int unsigned      KEY_LSB  = DEF_KEY_LSB,
    parameter logic [N_OUP-1:0] RST_MASK = '1,
    parameter int unsigned      CNT_W    = DEF_CNT_W,
    parameter int unsigned      EVT_W    = DEF_EVT_W,
    localparam int unsigned     KEY_W    = $clog2(N_KEYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    SNE_EVENT_STREAM.dst     evt_stream_dst,
    SNE_EVENT_STREAM.src     evt_stream_src,
    output logic [N_OUP-1:0] sel_o,
    output logic             sel_valid_o,
    input  logic             sel_ready_i,
    input  logic             cfg_we_i,
    input  logic [KEY_W-1:0] cfg_addr_i,
    input  logic [N_OUP-1:0] cfg_mask_i,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Output register stage.
    logic             full_q,     full_d;
    logic             evt_done_q, evt_done_d;
    logic             sel_done_q, sel_done_d;
    logic [EVT_W-1:0] evt_q,      evt_d;
    logic [N_OUP-1:0] mask_q,     mask_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [KEY_W-1:0] key;
    logic [N_OUP-1:0] lookup_mask;
    logic             src_valid;
    logic             sel_valid;
    logic             src_hs;
    logic             sel_hs;
    logic             drain;
    logic             dst_ready;
    logic             accept;
    logic             keep;
    logic             drop;

    assign key = evt_stream_dst.evt[KEY_LSB +: KEY_W];

    evt_route_table #(
        .N_OUP    (N_OUP),
        .N_KEYS   (N_KEYS),
        .RST_MASK (RST_MASK)
    ) u_table (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (cfg_we_i),
        .waddr_i (cfg_addr_i),
        .wdata_i (cfg_mask_i),
        .raddr_i (key),
        .rdata_o (lookup_mask)
    );

    // Each side is offered until its own handshake; the done flags remember
    // which side already completed so the entry retires once both have.
    assign src_valid = full_q && !evt_done_q;
    assign sel_valid = full_q && !sel_done_q;
    assign src_hs    = src_valid && evt_stream_src.ready;
    assign sel_hs    = sel_valid && sel_ready_i;

    // The stage empties this cycle when every side is either done or handshaking.
    assign drain     = full_q && (evt_done_q || evt_stream_src.ready)
                              && (sel_done_q || sel_ready_i);
    assign dst_ready = rst_ni && (!full_q || drain);
    assign accept    = evt_stream_dst.valid && dst_ready;
    assign keep      = accept && (lookup_mask != '0);
    assign drop      = accept && (lookup_mask == '0);

    // Next state of the output stage: load on a routed accept, clear on drain, else track done flags.
    always_comb begin
        full_d     = full_q;
        evt_done_d = evt_done_q;
        sel_done_d = sel_done_q;
        evt_d      = evt_q;
        mask_d     = mask_q;
        if (keep) begin
            full_d     = 1'b1;
            evt_done_d = 1'b0;
            sel_done_d = 1'b0;
            evt_d      = evt_stream_dst.evt;
            mask_d     = lookup_mask;
        end else if (drain) begin
            full_d     = 1'b0;
            evt_done_d = 1'b0;
            sel_done_d = 1'b0;
        end else if (full_q) begin
            evt_done_d = evt_done_q || src_hs;
            sel_done_d = sel_done_q || sel_hs;
        end
    end

    // Drop counter next state: clear wins over a simultaneous drop; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (drop && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any pending entry and partial handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q     <= 1'b0;
            evt_done_q <= 1'b0;
            sel_done_q <= 1'b0;
            evt_q      <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
        end else begin
            full_q     <= full_d;
            evt_done_q <= evt_done_d;
            sel_done_q <= sel_done_d;
            evt_q      <= evt_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
        end
    end

    assign evt_stream_dst.ready = dst_ready;
    assign evt_stream_src.valid = src_valid;
    assign evt_stream_src.evt   = evt_q;
    assign sel_o                = mask_q;
    assign sel_valid_o          = sel_valid;
    assign drop_cnt_o           = cnt_q;

endmodule

// File: tb/tb_evt_stream_route_sel.sv
// Directed bench for evt_stream_route_sel: a cycle-by-cycle vector table
// (inputs applied in a cycle, outputs expected in that same cycle before the
// edge) plus a hand-written reset-mid-transfer sequence.
module tb_evt_stream_route_sel;

    localparam int unsigned N_OUP  = 2;
    localparam int unsigned N_KEYS = 16;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned EVT_W  = 16;

    typedef struct {
        logic             dv;
        logic [EVT_W-1:0] evt;
        logic             sr;
        logic             lr;
        logic             we;
        logic [KEY_W-1:0] wa;
        logic [N_OUP-1:0] wm;
        logic             clr;
        logic             e_sv;
        logic             e_lv;
        logic             e_chk;
        logic [EVT_W-1:0] e_evt;
        logic [N_OUP-1:0] e_sel;
        logic             e_dr;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    SNE_EVENT_STREAM #(.EVT_W(EVT_W)) in_if ();
    SNE_EVENT_STREAM #(.EVT_W(EVT_W)) out_if ();

    logic [N_OUP-1:0] sel_o;
    logic             sel_valid_o;
    logic             sel_ready_i;
    logic             cfg_we_i;
    logic [KEY_W-1:0] cfg_addr_i;
    logic [N_OUP-1:0] cfg_mask_i;
    logic             cnt_clr_i;
    logic [CNT_W-1:0] drop_cnt_o;

    evt_stream_route_sel #(
        .N_OUP    (N_OUP),
        .N_KEYS   (N_KEYS),
        .KEY_LSB  (0),
        .RST_MASK ('1),
        .CNT_W    (CNT_W),
        .EVT_W    (EVT_W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .evt_stream_dst (in_if),
        .evt_stream_src (out_if),
        .sel_o          (sel_o),
        .sel_valid_o    (sel_valid_o),
        .sel_ready_i    (sel_ready_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_mask_i     (cfg_mask_i),
        .cnt_clr_i      (cnt_clr_i),
        .drop_cnt_o     (drop_cnt_o)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[$];

    // Scoreboard compare
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic dv, input logic [EVT_W-1:0] evt, input logic sr, input logic lr,
                       input logic we, input logic [KEY_W-1:0] wa, input logic [N_OUP-1:0] wm,
                       input logic clr, input logic e_sv, input logic e_lv, input logic e_chk,
                       input logic [EVT_W-1:0] e_evt, input logic [N_OUP-1:0] e_sel,
                       input logic e_dr, input logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.dv = dv; v.evt = evt; v.sr = sr; v.lr = lr; v.we = we; v.wa = wa; v.wm = wm;
        v.clr = clr; v.e_sv = e_sv; v.e_lv = e_lv; v.e_chk = e_chk; v.e_evt = e_evt;
        v.e_sel = e_sel; v.e_dr = e_dr; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // Driver: apply one vector's inputs
    task automatic drive(input vec_t v);
        in_if.valid  = v.dv;
        in_if.evt    = v.evt;
        out_if.ready = v.sr;
        sel_ready_i  = v.lr;
        cfg_we_i     = v.we;
        cfg_addr_i   = v.wa;
        cfg_mask_i   = v.wm;
        cnt_clr_i    = v.clr;
    endtask

    task automatic check_outs(input string tag, input logic e_sv, input logic e_lv,
                              input logic e_dr, input logic [CNT_W-1:0] e_cnt);
        chk({tag, " src_valid"}, 32'(out_if.valid), 32'(e_sv));
        chk({tag, " sel_valid"}, 32'(sel_valid_o),  32'(e_lv));
        chk({tag, " dst_ready"}, 32'(in_if.ready),  32'(e_dr));
        chk({tag, " drop_cnt"},  32'(drop_cnt_o),   32'(e_cnt));
    endtask

    task automatic check_data(input string tag, input logic [EVT_W-1:0] e_evt,
                              input logic [N_OUP-1:0] e_sel);
        chk({tag, " evt"},   32'(out_if.evt), 32'(e_evt));
        chk({tag, " sel_o"}, 32'(sel_o),      32'(e_sel));
    endtask

    initial begin
        vec_t idle;
        idle = '{dv:0, evt:0, sr:1, lr:1, we:0, wa:0, wm:0, clr:0,
                 e_sv:0, e_lv:0, e_chk:0, e_evt:0, e_sel:0, e_dr:0, e_cnt:0};

        // Back-to-back keys 0..3 with default broadcast table
        add(1,'hA000,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,0);
        add(1,'hA001,1,1, 0,0,0,0, 1,1,1,'hA000,3, 1,0);
        add(1,'hA002,1,1, 0,0,0,0, 1,1,1,'hA001,3, 1,0);
        add(1,'hA003,1,1, 0,0,0,0, 1,1,1,'hA002,3, 1,0);
        add(0,'h0000,1,1, 0,0,0,0, 1,1,1,'hA003,3, 1,0);
        add(0,'h0000,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,0);
        // table[5]=00, three key-5 drops, then a key-6 event
        add(0,'h0000,1,1, 1,5,0,0, 0,0,0,'h0000,0, 1,0);
        add(1,'hB005,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,0);
        add(1,'hB015,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,1);
        add(1,'hB025,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,2);
        add(1,'hB006,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,3);
        add(0,'h0000,1,1, 0,0,0,0, 1,1,1,'hB006,3, 1,3);
        add(0,'h0000,1,1, 0,0,0,1, 0,0,0,'h0000,0, 1,3);
        // table[2]=01 written in the cycle a key-2 event is looked up
        add(1,'hC002,1,1, 1,2,1,0, 0,0,0,'h0000,0, 1,0);
        add(1,'hC012,1,1, 0,0,0,0, 1,1,1,'hC002,3, 1,0);
        add(0,'h0000,1,1, 0,0,0,0, 1,1,1,'hC012,1, 1,0);
        // Split handshake: sel at t, evt at t+3
        add(1,'hD003,0,0, 0,0,0,0, 0,0,0,'h0000,0, 1,0);
        add(1,'hD004,0,1, 0,0,0,0, 1,1,1,'hD003,3, 0,0);
        add(1,'hD004,0,0, 0,0,0,0, 1,0,1,'hD003,3, 0,0);
        add(1,'hD004,0,0, 0,0,0,0, 1,0,1,'hD003,3, 0,0);
        add(1,'hD004,1,0, 0,0,0,0, 1,0,1,'hD003,3, 1,0);
        add(0,'h0000,1,1, 0,0,0,0, 1,1,1,'hD004,3, 1,0);
        // Five drops saturate the 2-bit counter, then clear beats a drop
        add(1,'hE005,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,0);
        add(1,'hE015,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,1);
        add(1,'hE025,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,2);
        add(1,'hE035,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,3);
        add(1,'hE045,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,3);
        add(1,'hE055,1,1, 0,0,0,1, 0,0,0,'h0000,0, 1,3);
        add(0,'h0000,1,1, 0,0,0,0, 0,0,0,'h0000,0, 1,0);

        // Reset: dst.ready must stay low even with an offered event
        rst_ni = 1'b0;
        drive(idle);
        in_if.valid = 1'b1;
        in_if.evt   = 16'h0001;
        repeat (3) step();
        check_outs("reset", 0, 0, 0, 0);
        check_data("reset", 16'h0000, 2'b00);
        rst_ni = 1'b1;
        drive(idle);

        // Vector table
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_sv, vecs[i].e_lv, vecs[i].e_dr, vecs[i].e_cnt);
            if (vecs[i].e_chk) check_data($sformatf("vec%0d", i), vecs[i].e_evt, vecs[i].e_sel);
            step();
        end

        // Reset mid-transfer with sel side already done
        drive(idle);
        in_if.valid = 1'b1; in_if.evt = 16'h1005;      // dropped, counter -> 1
        step();
        in_if.evt = 16'h1002; out_if.ready = 1'b0;     // routed with mask 01
        step();
        in_if.valid = 1'b0;
        #1;
        check_outs("rst_mid pend", 1, 1, 0, 1);
        check_data("rst_mid pend", 16'h1002, 2'b01);
        step();                                        // sel handshake only
        #1;
        check_outs("rst_mid seldone", 1, 0, 0, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid dst_ready in reset", 32'(in_if.ready), 32'd0);
        step();
        rst_ni = 1'b1;
        sel_ready_i = 1'b0;
        #1;
        check_outs("rst_mid after", 0, 0, 1, 0);
        check_data("rst_mid after", 16'h0000, 2'b00);
        // Table restored: keys 5 and 2 broadcast again
        sel_ready_i = 1'b1; out_if.ready = 1'b1;
        in_if.valid = 1'b1; in_if.evt = 16'h2005;
        step();
        in_if.evt = 16'h2002;
        #1;
        check_outs("restored k5", 1, 1, 1, 0);
        check_data("restored k5", 16'h2005, 2'b11);
        step();
        in_if.valid = 1'b0;
        #1;
        check_outs("restored k2", 1, 1, 1, 0);
        check_data("restored k2", 16'h2002, 2'b11);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
